adc_frame_rx: RTL

//  Receive-side parser for the ADC-sum UART frame: FE A5, then NSAMP x 16-bit samples (MSB byte, then LSB byte), then 33.

---
 rtl/adc_frame_rx_if.sv | 26 ++
 rtl/adc_frame_rx.sv | 109 ++++++++++
 2 files changed

// File: rtl/adc_frame_rx_if.sv
// rtl/adc_frame_rx_if.sv - byte input and frame/sample outputs of the ADC-sum frame parser
interface adc_frame_rx_if;
  logic [7:0]  rxd_in;
  logic        uart_tog;
  logic [15:0] sample_out;
  logic [5:0]  sample_idx;
  logic        sample_vld;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic        busy;

  modport master (
    output rxd_in, uart_tog,
    input  sample_out, sample_idx, sample_vld, frame_done, frame_err,
    input  err_code, frame_cnt, err_cnt, busy
  );

  modport slave (
    input  rxd_in, uart_tog,
    output sample_out, sample_idx, sample_vld, frame_done, frame_err,
    output err_code, frame_cnt, err_cnt, busy
  );
endinterface

// File: rtl/adc_frame_rx.sv
// rtl/adc_frame_rx.sv - ADC-sum UART frame parser: FE A5, NSAMP 16-bit samples, trailer
module adc_frame_rx #(
  parameter int         NSAMP   = 40,
  parameter logic [7:0] HDR0    = 8'hFE,
  parameter logic [7:0] HDR1    = 8'hA5,
  parameter logic [7:0] TAIL    = 8'h33,
  parameter int         TIMEOUT = 20000
) (
  input  logic           clk_40M,
  input  logic           rst,
  adc_frame_rx_if.slave  bus
);
  localparam logic [2:0] S_HUNT0 = 3'd0;
  localparam logic [2:0] S_HUNT1 = 3'd1;
  localparam logic [2:0] S_MSB   = 3'd2;
  localparam logic [2:0] S_LSB   = 3'd3;
  localparam logic [2:0] S_TAIL  = 3'd4;
  localparam int         GW      = $clog2(TIMEOUT + 1);
  localparam logic [5:0] LAST    = 6'(NSAMP - 1);

  logic [2:0]    state, state_nxt;
  logic          tog_q;
  logic          byte_stb;
  logic          timeout;
  logic [7:0]    hi;
  logic [5:0]    idx;
  logic [GW-1:0] gap;

  assign byte_stb = bus.uart_tog ^ tog_q;
  // A strobe in the expiry cycle suppresses the timeout so the byte is never lost.
  assign timeout  = (state != S_HUNT0) && !byte_stb && (gap == GW'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    if (byte_stb) begin
      case (state)
        S_HUNT0: if (bus.rxd_in == HDR0) state_nxt = S_HUNT1;
        S_HUNT1: begin
          if (bus.rxd_in == HDR1)      state_nxt = S_MSB;
          else if (bus.rxd_in == HDR0) state_nxt = S_HUNT1;
          else                         state_nxt = S_HUNT0;
        end
        S_MSB:   state_nxt = S_LSB;
        S_LSB:   state_nxt = (idx == LAST) ? S_TAIL : S_MSB;
        S_TAIL: begin
          if (bus.rxd_in == TAIL)      state_nxt = S_HUNT0;
          else if (bus.rxd_in == HDR0) state_nxt = S_HUNT1;
          else                         state_nxt = S_HUNT0;
        end
        default: state_nxt = S_HUNT0;
      endcase
    end else if (timeout) begin
      state_nxt = S_HUNT0;
    end
  end

  always_ff @(posedge clk_40M) begin
    tog_q <= bus.uart_tog;
    if (rst) begin
      state          <= S_HUNT0;
      hi             <= '0;
      idx            <= '0;
      gap            <= '0;
      bus.sample_out <= '0;
      bus.sample_idx <= '0;
      bus.sample_vld <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.err_code   <= '0;
      bus.frame_cnt  <= '0;
      bus.err_cnt    <= '0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.busy       <= (state_nxt != S_HUNT0);
      bus.sample_vld <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      gap            <= (byte_stb || state == S_HUNT0) ? '0 : gap + GW'(1);
      if (byte_stb) begin
        case (state)
          S_HUNT1: if (bus.rxd_in == HDR1) idx <= '0;
          S_MSB:   hi <= bus.rxd_in;
          S_LSB: begin
            bus.sample_out <= {hi, bus.rxd_in};
            bus.sample_idx <= idx;
            bus.sample_vld <= 1'b1;
            if (idx != LAST) idx <= idx + 6'd1;
          end
          S_TAIL: begin
            if (bus.rxd_in == TAIL) begin
              bus.frame_done <= 1'b1;
              bus.frame_cnt  <= bus.frame_cnt + 16'd1;
            end else begin
              bus.frame_err <= 1'b1;
              bus.err_code  <= 2'd1;
              if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end else if (timeout) begin
        bus.frame_err <= 1'b1;
        bus.err_code  <= 2'd2;
        if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
      end
    end
  end
endmodule
